// File: rtl/l1_stream_out_pkg.sv
// Shared definitions for the layer-1 stream-out stage.
//   - default widths of the layer-memory data/address buses and checksum
//   - layer-1 map size and raster index width
//   - layer-select encodings and the stream-out FSM state type
package l1_stream_out_pkg;

  localparam int unsigned DEF_DATA_W = 13;
  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_SIDE   = 32;
  localparam int unsigned DEF_SUM_W  = 23;

  localparam int unsigned L1_PIXELS  = DEF_SIDE * DEF_SIDE;  // 1024
  localparam int unsigned IDX_W      = 10;                   // {y[4:0],x[4:0]}

  localparam logic CSEL_L0 = 1'b0;
  localparam logic CSEL_L1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/l1_stream_out_fifo.sv
// skid_fifo2: 2-entry synchronous FIFO used to absorb the 1-cycle memory read
// latency and sink back-pressure.
//   clk     in   clock
//   rst_n   in   synchronous active-low reset (empties FIFO, clears storage)
//   push_i  in   write din_i (ignored only if full and not popping)
//   din_i   in   entry to write
//   pop_i   in   remove head (ignored when empty)
//   dout_o  out  current head entry
//   count_o out  occupancy 0..2
module skid_fifo2 #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/l1_stream_out.sv
// l1_stream_out: after the conv engine drops busy, reads the layer-1 map in
// raster order from the shared layer memory and streams it out over
// valid/ready with pixel index, last flag and running checksum.
//   clk, reset         clock; synchronous active-low reset
//   conv_busy          engine busy; 1->0 edge in IDLE starts a frame
//   crd/caddr_rd/csel  layer-memory read strobe, address, layer select
//   cdata_rd           read data, valid the cycle after crd
//   out_valid/ready    stream handshake
//   out_data/idx/last  pixel, raster index, final-pixel flag
//   checksum           unsigned sum of pixels handed over this frame
//   busy / done        frame in progress / 1-cycle completion pulse
module l1_stream_out
  import l1_stream_out_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned SIDE   = DEF_SIDE,
  parameter int unsigned SUM_W  = DEF_SUM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              conv_busy,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              csel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [SUM_W-1:0]  checksum,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NPIX  = SIDE * SIDE;
  localparam int unsigned CNT_W = $clog2(NPIX) + 1;
  localparam int unsigned ENT_W = DATA_W + IDX_W + 1;

  localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] END_RD   = CNT_W'(NPIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  state_e             state_q, state_d;
  logic               busy_q;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic               infl_q;
  logic [IDX_W-1:0]   infl_idx_q;
  logic [SUM_W-1:0]   sum_q, sum_d;

  logic               start;
  logic               hs;
  logic               issue;
  logic [2:0]         credit;
  logic [1:0]         fifo_count;
  logic [ENT_W-1:0]   fifo_din;
  logic [ENT_W-1:0]   fifo_dout;

  assign start = busy_q & ~conv_busy;

  assign out_valid = (fifo_count != 2'd0);
  assign hs        = out_valid & out_ready;
  assign {out_data, out_idx, out_last} = fifo_dout;

  // Returning read data is tagged with the index captured at issue time.
  assign fifo_din = {cdata_rd, infl_idx_q, (infl_idx_q == LAST_IDX)};

  // Credit counts the slot freed by a same-cycle pop so a full-rate sink sees
  // one pixel per cycle; a completely full FIFO never gets a new read.
  assign credit = 3'(fifo_count) + 3'(infl_q) - 3'(hs);
  assign issue  = (state_q == RUN) & (fifo_count != 2'd2) &
                  (credit < 3'd2) & (rd_cnt_q != END_RD);

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    sum_d    = sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          rd_cnt_d = '0;
          sum_d    = '0;
        end
      end
      RUN: begin
        if (issue && (rd_cnt_q == LAST_RD)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (issue) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    if (hs) begin
      sum_d = sum_q + SUM_W'(out_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      rd_cnt_q   <= '0;
      infl_q     <= 1'b0;
      infl_idx_q <= '0;
      sum_q      <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= conv_busy;
      rd_cnt_q <= rd_cnt_d;
      sum_q    <= sum_d;
      infl_q   <= issue;
      if (issue) begin
        infl_idx_q <= rd_cnt_q[IDX_W-1:0];
      end
    end
  end

  skid_fifo2 #(
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (infl_q),
    .din_i   (fifo_din),
    .pop_i   (hs),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  assign crd      = issue;
  assign caddr_rd = issue ? ADDR_W'(rd_cnt_q) : '0;
  assign csel     = ((state_q == RUN) || (state_q == DRAIN)) ? CSEL_L1 : CSEL_L0;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign checksum = sum_q;

endmodule

// File: tb/tb_l1_stream_out.sv
module tb_l1_stream_out;

  localparam int unsigned DW   = 13;
  localparam int unsigned AW   = 12;
  localparam int unsigned SW   = 23;
  localparam int unsigned NPIX = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          conv_busy = 1'b0;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          csel;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [9:0]    out_idx;
  logic          out_last;
  logic [SW-1:0] checksum;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [NPIX];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned ready_mode = 0;  // 0: always ready, 1: random 50%, 2: never

  // Reference-model state, owned by the monitor.
  int unsigned exp_idx = 0;
  int unsigned rd_addr_exp = 0;
  int unsigned occ = 0;
  int unsigned beat_total = 0;
  int unsigned done_total = 0;
  int unsigned last_total = 0;
  int unsigned rd_total = 0;
  bit          pend = 1'b0;
  bit          stalled = 1'b0;
  logic [DW-1:0] stall_data;
  logic [9:0]    stall_idx;

  always #5 clk = ~clk;

  l1_stream_out #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .SIDE   (32),
    .SUM_W  (SW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .conv_busy (conv_busy),
    .crd       (crd),
    .caddr_rd  (caddr_rd),
    .cdata_rd  (cdata_rd),
    .csel      (csel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .checksum  (checksum),
    .busy      (busy),
    .done      (done)
  );

  // Layer memory: one-cycle read latency.
  always @(posedge clk) begin
    if (crd) cdata_rd <= mem[caddr_rd[9:0]];
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: sequence/ordering, stall stability and occupancy model.
  always @(negedge clk) begin
    if (!reset) begin
      exp_idx     = 0;
      rd_addr_exp = 0;
      occ         = 0;
      pend        = 1'b0;
      stalled     = 1'b0;
    end else begin
      check("valid_vs_occ", 32'(out_valid), 32'(occ != 0));
      if (crd) begin
        check("crd_with_full_fifo", 32'(occ < 2), 32'd1);
        check("rd_addr", 32'(caddr_rd), rd_addr_exp);
        rd_total++;
        rd_addr_exp++;
        if (rd_addr_exp == NPIX) rd_addr_exp = 0;
      end
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(stall_data));
        check("stall_idx", 32'(out_idx), 32'(stall_idx));
      end
      if (out_valid && out_ready) begin
        check("beat_idx", 32'(out_idx), exp_idx);
        check("beat_data", 32'(out_data), 32'(mem[exp_idx]));
        check("beat_last", 32'(out_last), 32'(exp_idx == NPIX - 1));
        beat_total++;
        if (out_last) last_total++;
        exp_idx = (exp_idx == NPIX - 1) ? 0 : exp_idx + 1;
      end
      if (done) done_total++;
      stalled    = out_valid && !out_ready;
      stall_data = out_data;
      stall_idx  = out_idx;
      occ  = occ + (pend ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      pend = crd;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_crd", 32'(crd), 32'd0);
    check("rst_caddr", 32'(caddr_rd), 32'd0);
    check("rst_csel", 32'(csel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic start_frame();
    conv_busy = 1'b1;
    tick(2);
    conv_busy = 1'b0;
    tick(1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_csel", 32'(csel), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while (!done && n < 8000) begin
      tick(1);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    tick(1);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic wait_beats(input string tag, input int unsigned base, input int unsigned cnt);
    int unsigned n = 0;
    while ((beat_total - base) < cnt && n < 8000) begin
      tick(1);
      n++;
    end
    check({tag, "_beats_reached"}, 32'((beat_total - base) >= cnt), 32'd1);
  endtask

  function automatic int unsigned mem_sum();
    int unsigned s = 0;
    for (int unsigned a = 0; a < NPIX; a++) s += mem[a];
    return s;
  endfunction

  task automatic run_frame(input string tag, input int unsigned exp_sum);
    int unsigned b0, d0, l0;
    b0 = beat_total;
    d0 = done_total;
    l0 = last_total;
    start_frame();
    wait_done(tag);
    tick(3);
    check({tag, "_beats"}, beat_total - b0, NPIX);
    check({tag, "_done_count"}, done_total - d0, 32'd1);
    check({tag, "_last_count"}, last_total - l0, 32'd1);
    check({tag, "_checksum"}, 32'(checksum), exp_sum);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned b0, d0, r0, es;

    for (int unsigned a = 0; a < NPIX; a++) mem[a] = DW'(a % 8192);
    tick(2);
    do_reset();

    // 1: ramp map, sink always ready.
    ready_mode = 0;
    tick(2);
    run_frame("ramp", 32'd523776);

    // 2: random map, random back-pressure.
    for (int unsigned a = 0; a < NPIX; a++) mem[a] = DW'($urandom);
    ready_mode = 1;
    tick(2);
    run_frame("rand_bp", mem_sum());

    // 3: sink stalled for 100 cycles after start.
    for (int unsigned a = 0; a < NPIX; a++) mem[a] = DW'($urandom);
    ready_mode = 2;
    tick(3);
    r0 = rd_total;
    d0 = done_total;
    start_frame();
    tick(100);
    check("stall_reads", rd_total - r0, 32'd2);
    check("stall_valid_held", 32'(out_valid), 32'd1);
    check("stall_head_data", 32'(out_data), 32'(mem[0]));
    check("stall_head_idx", 32'(out_idx), 32'd0);
    ready_mode = 0;
    wait_done("stall");
    tick(3);
    check("stall_done_count", done_total - d0, 32'd1);
    check("stall_checksum", 32'(checksum), mem_sum());

    // 4: spurious conv_busy edge mid-frame.
    for (int unsigned a = 0; a < NPIX; a++) mem[a] = DW'($urandom);
    es = mem_sum();
    ready_mode = 1;
    tick(2);
    b0 = beat_total;
    d0 = done_total;
    start_frame();
    wait_beats("glitch", b0, 200);
    conv_busy = 1'b1;
    tick(3);
    conv_busy = 1'b0;
    wait_done("glitch");
    tick(100);
    check("glitch_done_count", done_total - d0, 32'd1);
    check("glitch_beats", beat_total - b0, NPIX);
    check("glitch_checksum", 32'(checksum), es);
    check("glitch_idle_busy", 32'(busy), 32'd0);

    // 5: reset at beat 500, then a fresh frame.
    b0 = beat_total;
    start_frame();
    wait_beats("midrst", b0, 500);
    do_reset();
    check("midrst_idle_valid", 32'(out_valid), 32'd0);
    run_frame("after_rst", es);

    // 6: extreme maps.
    ready_mode = 0;
    for (int unsigned a = 0; a < NPIX; a++) mem[a] = '0;
    tick(2);
    run_frame("zeros", 32'd0);
    for (int unsigned a = 0; a < NPIX; a++) mem[a] = 13'h1FFF;
    tick(2);
    run_frame("ones", 32'd8387584);

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
